// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART definitions: line-state encodings and parity helpers, also used by the RX stage.
package uart_tx_serializer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic PARITY_MODE_EVEN = 1'b0;
  localparam logic PARITY_MODE_ODD  = 1'b1;

  // Widest supported character is 9 bits; narrower bytes are zero-extended.
  function automatic logic parity_of(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_baud_gen.sv
// Bit-period down-counter: load presets BAUD_DIV-1, bit_end flags the final clock of a bit.
module uart_tx_serializer_baud_gen #(
  parameter int BAUD_DIV  = 434,
  parameter int CNT_WIDTH = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic bit_end
);

  logic [CNT_WIDTH-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_WIDTH'(BAUD_DIV - 1);
    end else if (run && (count != '0)) begin
      count <= count - CNT_WIDTH'(1);
    end
  end

  assign bit_end = run && (count == '0);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer draining a first-word-fall-through FIFO: start, LSB-first data,
// optional parity, 1 or 2 stop bits, with back-to-back frames and no idle gap.
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_DIV   = 434,
  parameter int CNT_WIDTH  = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_deQ,
  output logic                  tx,
  output logic                  busy,
  output state_t                state
);

  localparam int                IDX_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_WIDTH - 1);
  localparam logic              LAST_STOP = (STOP_BITS == 2);
  localparam logic              ODD_BIT   = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

  state_t                state_d;
  logic [DATA_WIDTH-1:0] shift, shift_d;
  logic [IDX_W-1:0]      bit_idx, bit_idx_d;
  logic                  stop_idx, stop_idx_d;
  logic                  parity, parity_d;
  logic                  tx_d;
  logic                  load, run, bit_end, launch_ok, capture;

  // FIFO handshake: the FIFO's "valid" is ~fifo_empty and fifo_data is valid whenever it is;
  // fifo_deQ acts as "ready" and a byte transfers on any edge where both are high.
  assign launch_ok = enable && !fifo_empty;
  assign run       = (state != S_IDLE);
  assign busy      = run;

  uart_tx_serializer_baud_gen #(
    .BAUD_DIV  (BAUD_DIV),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_baud (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .run     (run),
    .bit_end (bit_end)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      shift    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      parity   <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_d;
      shift    <= shift_d;
      bit_idx  <= bit_idx_d;
      stop_idx <= stop_idx_d;
      parity   <= parity_d;
      tx       <= tx_d;
    end
  end

  always_comb begin
    state_d    = state;
    shift_d    = shift;
    bit_idx_d  = bit_idx;
    stop_idx_d = stop_idx;
    parity_d   = parity;
    load       = 1'b0;
    capture    = 1'b0;
    fifo_deQ   = 1'b0;

    case (state)
      S_IDLE: begin
        if (launch_ok) capture = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          load    = 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          load = 1'b1;
          if (bit_idx == LAST_IDX) begin
            state_d    = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx + IDX_W'(1);
            shift_d   = shift >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d    = S_STOP;
          stop_idx_d = 1'b0;
          load       = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_idx != LAST_STOP) begin
            stop_idx_d = 1'b1;
            load       = 1'b1;
          end else if (launch_ok) begin
            capture = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Parity is frozen at capture so later fifo_data changes cannot disturb the frame.
    if (capture) begin
      fifo_deQ   = 1'b1;
      shift_d    = fifo_data;
      parity_d   = parity_of(9'(fifo_data), ODD_BIT);
      bit_idx_d  = '0;
      stop_idx_d = 1'b0;
      state_d    = S_START;
      load       = 1'b1;
    end

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench: three serializer configurations fed from queue-modelled FWFT FIFOs.
module tb_uart_tx_serializer;
  import uart_tx_serializer_pkg::*;

  localparam int BD = 4;

  logic       clock, reset;
  logic [2:0] enable, fifo_empty, deq, tx, busy;
  logic [7:0] d0, d1, d2;
  state_t     st0, st1, st2;
  logic [7:0] fq0[$], fq1[$], fq2[$];
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         failures = 0;

  uart_tx_serializer #(.DATA_WIDTH(8), .BAUD_DIV(BD), .CNT_WIDTH(16),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clock(clock), .reset(reset), .enable(enable[0]), .fifo_empty(fifo_empty[0]),
    .fifo_data(d0), .fifo_deQ(deq[0]), .tx(tx[0]), .busy(busy[0]), .state(st0));

  uart_tx_serializer #(.DATA_WIDTH(8), .BAUD_DIV(BD), .CNT_WIDTH(16),
    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
    .clock(clock), .reset(reset), .enable(enable[1]), .fifo_empty(fifo_empty[1]),
    .fifo_data(d1), .fifo_deQ(deq[1]), .tx(tx[1]), .busy(busy[1]), .state(st1));

  uart_tx_serializer #(.DATA_WIDTH(8), .BAUD_DIV(BD), .CNT_WIDTH(16),
    .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
    .clock(clock), .reset(reset), .enable(enable[2]), .fifo_empty(fifo_empty[2]),
    .fifo_data(d2), .fifo_deQ(deq[2]), .tx(tx[2]), .busy(busy[2]), .state(st2));

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: FIFO model presents the head byte first-word-fall-through
  task automatic refresh();
    fifo_empty[0] = (fq0.size() == 0);
    fifo_empty[1] = (fq1.size() == 0);
    fifo_empty[2] = (fq2.size() == 0);
    d0 = (fq0.size() != 0) ? fq0[0] : 8'h00;
    d1 = (fq1.size() != 0) ? fq1[0] : 8'h00;
    d2 = (fq2.size() != 0) ? fq2[0] : 8'h00;
  endtask

  task automatic push(input int k, input logic [7:0] b);
    case (k)
      0: fq0.push_back(b);
      1: fq1.push_back(b);
      default: fq2.push_back(b);
    endcase
    refresh();
  endtask

  // Advance one clock: a dequeue seen before the edge pops the model after it; ends on negedge.
  task automatic tick();
    logic [2:0] pop;
    #1;
    pop = deq;
    @(posedge clock);
    #1;
    if (pop[0] && fq0.size() != 0) void'(fq0.pop_front());
    if (pop[1] && fq1.size() != 0) void'(fq1.pop_front());
    if (pop[2] && fq2.size() != 0) void'(fq2.pop_front());
    refresh();
    @(negedge clock);
  endtask

  task automatic wait_deq(input int k, input string tag);
    bit found = 1'b0;
    #1;
    for (int i = 0; i < 300; i++) begin
      if (deq[k]) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  // Scoreboard: per-cycle line check against a hand-written bit pattern plus mid-bit decode.
  task automatic run_frame(input int k, input logic [11:0] pat, input int nbits,
                           input logic last_deq, input bit clr_en, input string tag);
    logic [7:0] got = '0;
    for (int i = 0; i < nbits * BD; i++) begin
      tick();
      if (i == 0 && clr_en) enable[k] = 1'b0;
      chk({tag, "_tx"}, 32'(tx[k]), 32'(pat[i / BD]));
      chk({tag, "_busy"}, 32'(busy[k]), 32'd1);
      if ((i % BD) == 2 && (i / BD) >= 1 && (i / BD) <= 8) got[(i / BD) - 1] = tx[k];
      if (i == nbits * BD - 1) chk({tag, "_last_deq"}, 32'(deq[k]), 32'(last_deq));
      else                     chk({tag, "_deq"}, 32'(deq[k]), 32'd0);
    end
    chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) chk({tag, "_byte"}, 32'(got), 32'(exp_q.pop_front()));
  endtask

  task automatic check_idle(input int k, input string tag);
    tick();
    chk({tag, "_busy_end"}, 32'(busy[k]), 32'd0);
    chk({tag, "_tx_idle"}, 32'(tx[k]), 32'd1);
  endtask

  initial begin
    reset  = 1'b0;
    enable = 3'b000;
    refresh();
    repeat (3) @(negedge clock);
    #1;
    chk("rst_tx", 32'(tx), 32'h7);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_deq", 32'(deq), 32'h0);
    chk("rst_state0", 32'(st0), 32'(S_IDLE));
    chk("rst_state1", 32'(st1), 32'(S_IDLE));
    chk("rst_state2", 32'(st2), 32'(S_IDLE));
    @(negedge clock);
    reset     = 1'b1;
    enable[0] = 1'b1;

    // Empty FIFO with enable high: line stays idle
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_tx", 32'(tx[0]), 32'd1);
      chk("idle_busy", 32'(busy[0]), 32'd0);
      chk("idle_deq", 32'(deq[0]), 32'd0);
    end

    // Single 0xA5 frame
    exp_q.push_back(8'hA5);
    push(0, 8'hA5);
    wait_deq(0, "a5_deq");
    run_frame(0, {2'b00, 1'b1, 8'hA5, 1'b0}, 10, 1'b0, 1'b0, "a5");
    check_idle(0, "a5");

    // Even parity, two stop bits: 0x07 -> parity 1
    enable[1] = 1'b1;
    exp_q.push_back(8'h07);
    push(1, 8'h07);
    wait_deq(1, "par_even_deq");
    run_frame(1, {2'b11, 1'b1, 8'h07, 1'b0}, 12, 1'b0, 1'b0, "par_even");
    check_idle(1, "par_even");

    // Odd parity, one stop bit: 0x07 -> parity 0
    enable[2] = 1'b1;
    exp_q.push_back(8'h07);
    push(2, 8'h07);
    wait_deq(2, "par_odd_deq");
    run_frame(2, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 1'b0, 1'b0, "par_odd");
    check_idle(2, "par_odd");

    // Back-to-back frames with no idle gap
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    wait_deq(0, "b2b_deq");
    run_frame(0, {2'b00, 1'b1, 8'h11, 1'b0}, 10, 1'b1, 1'b0, "b2b_11");
    run_frame(0, {2'b00, 1'b1, 8'h22, 1'b0}, 10, 1'b1, 1'b0, "b2b_22");
    run_frame(0, {2'b00, 1'b1, 8'h33, 1'b0}, 10, 1'b0, 1'b0, "b2b_33");
    check_idle(0, "b2b");

    // Reset during data bit 3 of 0xFF aborts the frame
    push(0, 8'hFF);
    wait_deq(0, "abort_deq");
    repeat (18) tick();
    chk("abort_pre_state", 32'(st0), 32'(S_DATA));
    reset = 1'b0;
    #1;
    chk("abort_tx", 32'(tx[0]), 32'd1);
    chk("abort_state", 32'(st0), 32'(S_IDLE));
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_deq", 32'(deq[0]), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_busy", 32'(busy[0]), 32'd0);
    exp_q.push_back(8'h3C);
    push(0, 8'h3C);
    wait_deq(0, "post_rst_deq");
    run_frame(0, {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 1'b0, 1'b0, "post_rst");
    check_idle(0, "post_rst");

    // enable dropped mid-frame: frame completes, next byte waits
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h66);
    push(0, 8'h5A);
    push(0, 8'h66);
    wait_deq(0, "en_off_deq");
    run_frame(0, {2'b00, 1'b1, 8'h5A, 1'b0}, 10, 1'b0, 1'b1, "en_off");
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("en_off_hold_deq", 32'(deq[0]), 32'd0);
      chk("en_off_hold_tx", 32'(tx[0]), 32'd1);
      chk("en_off_hold_busy", 32'(busy[0]), 32'd0);
    end
    enable[0] = 1'b1;
    #1;
    chk("reen_deq", 32'(deq[0]), 32'd1);
    run_frame(0, {2'b00, 1'b1, 8'h66, 1'b0}, 10, 1'b0, 1'b0, "reen");
    check_idle(0, "reen");

    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
